// File: rtl/lcd_pkg.sv
// Shared LCD/frame-buffer definitions: FSM state encoding, counter widths,
// default frame-buffer bases and the frame-size helper.
package lcd_pkg;

  localparam int unsigned REMAIN_W = 20;
  localparam int unsigned LEN_W    = 10;
  localparam int unsigned LEVEL_W  = 11;

  localparam int unsigned DEF_H_DISP    = 640;
  localparam int unsigned DEF_V_DISP    = 480;
  localparam int unsigned DEF_BUF0_BASE = 32'h0000_0000;
  localparam int unsigned DEF_BUF1_BASE = 32'h0010_0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_CHECK     = 3'd2,
    ST_REQ       = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

  localparam int unsigned FRAME_WORDS = frame_words(DEF_H_DISP, DEF_V_DISP);

endpackage

// File: rtl/lcd_read_scheduler_if.sv
// LCD/FIFO/SDRAM-read signal bundle seen by the read scheduler.
interface lcd_read_scheduler_if #(
  parameter int unsigned ADDR_W = 24
);
  import lcd_pkg::*;

  logic               lcd_framesync;
  logic               lcd_request;
  logic               wr_buf;
  logic [LEVEL_W-1:0] fifo_level;
  logic               fifo_flush;
  logic               rd_req;
  logic [ADDR_W-1:0]  rd_addr;
  logic [LEN_W-1:0]   rd_len;
  logic               rd_ack;
  logic               rd_done;
  logic               frame_buf;
  logic               underflow;

  modport master (
    input  lcd_framesync, lcd_request, wr_buf, fifo_level, rd_ack, rd_done,
    output fifo_flush, rd_req, rd_addr, rd_len, frame_buf, underflow
  );

  modport slave (
    output lcd_framesync, lcd_request, wr_buf, fifo_level, rd_ack, rd_done,
    input  fifo_flush, rd_req, rd_addr, rd_len, frame_buf, underflow
  );

endinterface

// File: rtl/vsync_edge_det.sv
// Two-flop sample of the active-low vsync and a falling-edge (frame start) pulse.
module vsync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic vsync_n,
  output logic fall_c
);

  logic cur_q;
  logic prev_q;

  // Both stages reset high so a released reset never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      cur_q  <= vsync_n;
      prev_q <= cur_q;
    end
  end

  assign fall_c = prev_q & ~cur_q;

endmodule

// File: rtl/lcd_read_scheduler.sv
// Issues SDRAM burst reads to keep the LCD line FIFO above its low watermark,
// selecting and flushing the display buffer at every frame start.
module lcd_read_scheduler
  import lcd_pkg::*;
#(
  parameter int unsigned H_DISP    = DEF_H_DISP,
  parameter int unsigned V_DISP    = DEF_V_DISP,
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned LOW_WM    = 512,
  parameter int unsigned ADDR_W    = 24,
  parameter logic [ADDR_W-1:0] BUF0_BASE = ADDR_W'(DEF_BUF0_BASE),
  parameter logic [ADDR_W-1:0] BUF1_BASE = ADDR_W'(DEF_BUF1_BASE)
) (
  input  logic                clk,
  input  logic                rst,
  lcd_read_scheduler_if.master bus
);

  localparam int unsigned FRM_WORDS = frame_words(H_DISP, V_DISP);

  state_t              state;
  logic [REMAIN_W-1:0] remain;
  logic [ADDR_W-1:0]   addr;
  logic                pending;
  logic                frame_start_c;
  logic                below_wm_c;
  logic [LEN_W-1:0]    burst_len_c;

  vsync_edge_det u_vsync_edge_det (
    .clk     (clk),
    .rst     (rst),
    .vsync_n (bus.lcd_framesync),
    .fall_c  (frame_start_c)
  );

  assign below_wm_c  = (bus.fifo_level <= LEVEL_W'(LOW_WM));
  assign burst_len_c = (remain < REMAIN_W'(BURST_LEN)) ? LEN_W'(remain) : LEN_W'(BURST_LEN);

  // Scheduler FSM with counters; every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      remain         <= '0;
      addr           <= '0;
      pending        <= 1'b0;
      bus.fifo_flush <= 1'b0;
      bus.rd_req     <= 1'b0;
      bus.rd_addr    <= '0;
      bus.rd_len     <= '0;
      bus.frame_buf  <= 1'b0;
      bus.underflow  <= 1'b0;
    end else begin
      bus.fifo_flush <= 1'b0;

      if ((state != ST_FLUSH) && bus.lcd_request && (bus.fifo_level == '0)) begin
        bus.underflow <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (frame_start_c) begin
            state          <= ST_FLUSH;
            bus.fifo_flush <= 1'b1;
          end
        end

        ST_FLUSH: begin
          bus.frame_buf <= ~bus.wr_buf;
          addr          <= bus.wr_buf ? BUF0_BASE : BUF1_BASE;
          remain        <= REMAIN_W'(FRM_WORDS);
          bus.underflow <= 1'b0;
          pending       <= 1'b0;
          state         <= ST_CHECK;
        end

        ST_CHECK: begin
          if (frame_start_c) begin
            state          <= ST_FLUSH;
            bus.fifo_flush <= 1'b1;
          end else if (remain == '0) begin
            state <= ST_IDLE;
          end else if (below_wm_c) begin
            state       <= ST_REQ;
            bus.rd_req  <= 1'b1;
            bus.rd_addr <= addr;
            bus.rd_len  <= burst_len_c;
          end
        end

        ST_REQ: begin
          if (frame_start_c) begin
            pending <= 1'b1;
          end
          if (bus.rd_ack) begin
            bus.rd_req <= 1'b0;
            addr       <= addr + ADDR_W'(bus.rd_len);
            remain     <= remain - REMAIN_W'(bus.rd_len);
            state      <= ST_WAIT_DONE;
          end
        end

        ST_WAIT_DONE: begin
          if (frame_start_c) begin
            pending <= 1'b1;
          end
          // A frame start seen during the burst is honoured only once it lands.
          if (bus.rd_done) begin
            if (pending || frame_start_c) begin
              state          <= ST_FLUSH;
              bus.fifo_flush <= 1'b1;
            end else begin
              state <= ST_CHECK;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
